// File: rtl/gact_tb_cigar_if.sv
// gact_tb_cigar_if: run-length record stream from the traceback/CIGAR block to the
// host result writer.
//   op_valid  record valid (producer holds it and the fields until op_ready)
//   op_ready  consumer accept
//   op_code   1=M (diag), 2=I (query advance), 3=D (ref advance)
//   op_len    run length, at least 1
// Modports: master = producer (gact_tb_cigar), slave = consumer (host / CIGAR writer).
interface gact_tb_cigar_if #(
  parameter int unsigned LW = 18
);
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [LW-1:0] op_len;

  modport master (output op_valid, output op_code, output op_len, input op_ready);
  modport slave  (input op_valid, input op_code, input op_len, output op_ready);
endinterface

// File: rtl/gact_tb_cigar.sv
// gact_tb_cigar: drains the packed traceback-direction BRAM after a GACT tile completes,
// unpacks 2-bit directions in traceback order and merges runs of equal directions into
// (op, len) records on a valid/ready stream.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle pulse, accepted only when idle
//   num_tb_steps     directions stored (sampled on start)
//   dir_total_count  BRAM words written (sampled on start)
//   dir_rd_addr      BRAM read address (read data returns one cycle later)
//   dir_data_out     BRAM read data, NUM_DIR_BLOCK directions per word, first in the MSBs
//   busy             operation in progress
//   done             one-cycle completion pulse (also on count-mismatch error)
//   error            sticky word-count mismatch, cleared by the next accepted start
//   op               record stream (gact_tb_cigar_if.master)
//
// Optional feature, macro GACT_TB_CIGAR_TALLY_EN: adds ref_bases / query_bases outputs that
// accumulate the accepted record lengths consumed on each sequence (M/D -> ref, M/I -> query).
module gact_tb_cigar #(
  parameter int unsigned NUM_DIR_BLOCK       = 32,
  parameter int unsigned DIR_BRAM_ADDR_WIDTH = 5,
  parameter int unsigned MAX_TILE_SIZE       = 512,
  localparam int unsigned LW                 = 2 * $clog2(MAX_TILE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LW-1:0]                  num_tb_steps,
  input  logic [DIR_BRAM_ADDR_WIDTH-1:0] dir_total_count,
  output logic [DIR_BRAM_ADDR_WIDTH-1:0] dir_rd_addr,
  input  logic [2*NUM_DIR_BLOCK-1:0]     dir_data_out,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
`ifdef GACT_TB_CIGAR_TALLY_EN
  output logic [LW-1:0]                  ref_bases,
  output logic [LW-1:0]                  query_bases,
`endif
  gact_tb_cigar_if.master                op
);

  localparam int unsigned WW = 2 * NUM_DIR_BLOCK;
  localparam int unsigned CW = $clog2(NUM_DIR_BLOCK) + 1;
  localparam int unsigned AW = DIR_BRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StUnpack, StFlush, StFin} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [WW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    run_code_q, run_code_d;
  logic [LW-1:0] run_len_q, run_len_d;
  logic          ov_q, ov_d;
  logic [1:0]    oc_q, oc_d;
  logic [LW-1:0] ol_q, ol_d;
  logic          error_q, error_d;
`ifdef GACT_TB_CIGAR_TALLY_EN
  logic [LW-1:0] ref_q, ref_d;
  logic [LW-1:0] qry_q, qry_d;
`endif

  logic          accept, stall, count_mismatch, last_word;
  logic [CW-1:0] load_cnt;
  logic [1:0]    dir;

  assign accept = ov_q & op.op_ready;
  assign stall  = ov_q & ~op.op_ready;

  // Words required = ceil(num_tb_steps / NUM_DIR_BLOCK); one extra bit avoids overflow.
  assign count_mismatch =
      (({1'b0, num_tb_steps} + (LW+1)'(NUM_DIR_BLOCK - 1)) / (LW+1)'(NUM_DIR_BLOCK))
      != (LW+1)'(dir_total_count);

  assign last_word = (addr_q == last_addr_q);
  // A partial final word holds only rem_q directions, right-aligned in the word.
  assign load_cnt  = (last_word && rem_q != '0) ? rem_q : CW'(NUM_DIR_BLOCK);
  assign dir       = shift_q[WW-1 -: 2];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    rem_d       = rem_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    run_code_d  = run_code_q;
    run_len_d   = run_len_q;
    ov_d        = ov_q;
    oc_d        = oc_q;
    ol_d        = ol_q;
    error_d     = error_q;
`ifdef GACT_TB_CIGAR_TALLY_EN
    ref_d       = ref_q;
    qry_d       = qry_q;
    if (accept) begin
      if (oc_q == 2'd1 || oc_q == 2'd3) ref_d = ref_q + ol_q;
      if (oc_q == 2'd1 || oc_q == 2'd2) qry_d = qry_q + ol_q;
    end
`endif
    if (accept) ov_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d     = 1'b0;
          addr_d      = '0;
          last_addr_d = dir_total_count - AW'(1);
          rem_d       = CW'(num_tb_steps % LW'(NUM_DIR_BLOCK));
          run_len_d   = '0;
`ifdef GACT_TB_CIGAR_TALLY_EN
          ref_d       = '0;
          qry_d       = '0;
`endif
          if (count_mismatch) begin
            error_d = 1'b1;
            state_d = StFin;
          end else if (num_tb_steps == '0) begin
            state_d = StFin;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        // Left-align the valid field so the first direction sits in the top two bits.
        shift_d = dir_data_out << {CW'(NUM_DIR_BLOCK) - load_cnt, 1'b0};
        cnt_d   = load_cnt;
        state_d = StUnpack;
      end
      StUnpack: begin
        if (!stall) begin
          shift_d = shift_q << 2;
          cnt_d   = cnt_q - CW'(1);
          if (dir != 2'd0) begin
            if (run_len_q == '0) begin
              run_code_d = dir;
              run_len_d  = LW'(1);
            end else if (dir == run_code_q) begin
              run_len_d = run_len_q + LW'(1);
            end else begin
              ov_d       = 1'b1;
              oc_d       = run_code_q;
              ol_d       = run_len_q;
              run_code_d = dir;
              run_len_d  = LW'(1);
            end
          end
          if (cnt_q == CW'(1)) begin
            if (last_word) begin
              state_d = StFlush;
            end else begin
              addr_d  = addr_q + AW'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StFlush: begin
        // Stay until the open run has been presented and every record accepted, so done
        // lands exactly one cycle after the final acceptance.
        if (!stall) begin
          if (run_len_q != '0) begin
            ov_d      = 1'b1;
            oc_d      = run_code_q;
            ol_d      = run_len_q;
            run_len_d = '0;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      run_code_q  <= '0;
      run_len_q   <= '0;
      ov_q        <= 1'b0;
      oc_q        <= '0;
      ol_q        <= '0;
      error_q     <= 1'b0;
`ifdef GACT_TB_CIGAR_TALLY_EN
      ref_q       <= '0;
      qry_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      run_code_q  <= run_code_d;
      run_len_q   <= run_len_d;
      ov_q        <= ov_d;
      oc_q        <= oc_d;
      ol_q        <= ol_d;
      error_q     <= error_d;
`ifdef GACT_TB_CIGAR_TALLY_EN
      ref_q       <= ref_d;
      qry_q       <= qry_d;
`endif
    end
  end

  assign dir_rd_addr = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);
  assign error       = error_q;
  assign op.op_valid = ov_q;
  assign op.op_code  = oc_q;
  assign op.op_len   = ol_q;
`ifdef GACT_TB_CIGAR_TALLY_EN
  assign ref_bases   = ref_q;
  assign query_bases = qry_q;
`endif

endmodule

// File: tb/tb_gact_tb_cigar.sv
// Scoreboard bench for gact_tb_cigar: stimulus packs direction tiles into a BRAM model and
// pushes the expected run-length records; an independent monitor pops and compares on
// every accepted record.
module tb_gact_tb_cigar;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int LW = 18;

  typedef logic [1:0] dq_t[$];
  typedef struct packed {
    logic [1:0]    code;
    logic [LW-1:0] len;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_tb_steps = '0;
  logic [AW-1:0] dir_total_count = '0;
  logic [AW-1:0] dir_rd_addr;
  logic [2*N-1:0] dir_data_out = '0;
  logic          busy, done, error;
`ifdef GACT_TB_CIGAR_TALLY_EN
  logic [LW-1:0] ref_bases, query_bases;
`endif

  gact_tb_cigar_if #(.LW(LW)) op_if ();

  gact_tb_cigar dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_tb_steps    (num_tb_steps),
    .dir_total_count (dir_total_count),
    .dir_rd_addr     (dir_rd_addr),
    .dir_data_out    (dir_data_out),
    .busy            (busy),
    .done            (done),
    .error           (error),
`ifdef GACT_TB_CIGAR_TALLY_EN
    .ref_bases       (ref_bases),
    .query_bases     (query_bases),
`endif
    .op              (op_if.master)
  );

  always #5 clk = ~clk;

  logic [2*N-1:0] mem [1<<AW];
  always @(posedge clk) dir_data_out <= mem[dir_rd_addr];

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_acc_cyc = -1;
  int   exp_ref, exp_qry;
  bit   ready_rand = 1'b0;
  bit   hold_arm = 1'b0;
  int   hold_cnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Downstream ready: optional random backpressure, or a 10-cycle hold on the first record.
  initial begin
    op_if.op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        op_if.op_ready = 1'b0;
        hold_cnt--;
      end else if (hold_arm && op_if.op_valid) begin
        op_if.op_ready = 1'b0;
        hold_cnt = 9;
        hold_arm = 1'b0;
      end else begin
        op_if.op_ready = ready_rand ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: protocol stability while stalled, and scoreboard compare on acceptance.
  bit   stalled = 1'b0;
  rec_t prev;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", op_if.op_valid, 1);
        check("hold_code", op_if.op_code, prev.code);
        check("hold_len", op_if.op_len, prev.len);
      end
      if (op_if.op_valid && op_if.op_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_record: got code %0d len %0d expected none",
                   op_if.op_code, op_if.op_len);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("rec_code", op_if.op_code, e.code);
          check("rec_len", op_if.op_len, e.len);
        end
        last_acc_cyc = cyc;
      end
      stalled = op_if.op_valid && !op_if.op_ready;
      prev.code = op_if.op_code;
      prev.len  = op_if.op_len;
    end
  end

  // Reference: drop zero codes, then run-length encode what remains.
  task automatic model(input dq_t d);
    int code = 0;
    int len = 0;
    exp_ref = 0;
    exp_qry = 0;
    foreach (d[k]) begin
      if (d[k] == 2'd0) continue;
      if (len == 0) begin
        code = d[k]; len = 1;
      end else if (d[k] == code) begin
        len++;
      end else begin
        push_rec(code, len);
        code = d[k]; len = 1;
      end
    end
    if (len > 0) push_rec(code, len);
  endtask

  task automatic push_rec(input int code, input int len);
    rec_t r;
    r.code = code[1:0];
    r.len  = len[LW-1:0];
    exp_q.push_back(r);
    if (code == 1 || code == 3) exp_ref += len;
    if (code == 1 || code == 2) exp_qry += len;
  endtask

  // Packs the tile, loads expectations and pulses start. Returns whether an error is due.
  task automatic launch(input int steps, input int count, input dq_t d, output bit exp_err);
    int w, r, nw, wi, i;
    r = steps % N;
    w = (steps + N - 1) / N;
    for (int k = 0; k < (1 << AW); k++) mem[k] = {$urandom, $urandom};
    for (int k = 0; k < steps; k++) begin
      wi = k / N;
      i  = k % N;
      nw = (wi == w - 1 && r != 0) ? r : N;
      mem[wi][2*(nw-1-i) +: 2] = d[k];
    end
    exp_err = (w != count);
    if (!exp_err) model(d);
    else begin
      exp_ref = 0;
      exp_qry = 0;
    end
    last_acc_cyc = -1;
    @(posedge clk);
    #1;
    num_tb_steps    = steps[LW-1:0];
    dir_total_count = count[AW-1:0];
    start           = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_tile(input string tag, input int steps, input int count, input dq_t d);
    bit exp_err;
    bit got;
    int lat;
    int n_exp;
    launch(steps, count, d, exp_err);
    n_exp = exp_q.size();
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s done_timeout: got no done expected done within 6000 cycles", tag);
    end else begin
      check({tag, "_error"}, error, exp_err);
      check({tag, "_drained"}, exp_q.size(), 0);
      if (exp_err) check({tag, "_err_latency"}, lat, 0);
      else if (n_exp > 0) check({tag, "_done_after_accept"}, cyc, last_acc_cyc + 1);
`ifdef GACT_TB_CIGAR_TALLY_EN
      check({tag, "_ref_bases"}, ref_bases, exp_ref);
      check({tag, "_query_bases"}, query_bases, exp_qry);
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
    end
    exp_q.delete();
  endtask

  function automatic dq_t rand_dirs(input int steps);
    dq_t d;
    logic [1:0] c;
    c = 2'($urandom_range(3));
    for (int k = 0; k < steps; k++) begin
      if ($urandom_range(3) == 0) c = 2'($urandom_range(3));
      d.push_back(c);
    end
    return d;
  endfunction

  function automatic dq_t const_dirs(input int steps, input logic [1:0] c);
    dq_t d;
    for (int k = 0; k < steps; k++) d.push_back(c);
    return d;
  endfunction

  initial begin
    dq_t d;
    int  s;
    bit  e;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_valid", op_if.op_valid, 0);
    check("rst_code", op_if.op_code, 0);
    check("rst_len", op_if.op_len, 0);
    check("rst_addr", dir_rd_addr, 0);

    run_tile("full_m32", 32, 1, const_dirs(32, 2'd1));

    d = {2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    run_tile("mid", 5, 1, d);

    run_tile("span40", 40, 2, const_dirs(40, 2'd1));

    hold_arm = 1'b1;
    run_tile("span40_hold", 40, 2, const_dirs(40, 2'd1));
    hold_arm = 1'b0;

    run_tile("mismatch", 40, 1, const_dirs(40, 2'd1));
    repeat (3) @(negedge clk);
    check("error_sticky", error, 1);
    d = rand_dirs(20);
    run_tile("after_err", 20, 1, d);

    d = {};
    run_tile("empty", 0, 0, d);

    ready_rand = 1'b1;
    for (int t = 0; t < 16; t++) begin
      s = $urandom_range(300, 1);
      run_tile("rand", s, (s + N - 1) / N, rand_dirs(s));
    end

    // Reset in the middle of unpacking, then a clean tile.
    d = rand_dirs(64);
    launch(64, 2, d, e);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", op_if.op_valid, 0);
    check("mid_rst_code", op_if.op_code, 0);
    check("mid_rst_len", op_if.op_len, 0);
    check("mid_rst_addr", dir_rd_addr, 0);
    repeat (10) begin
      @(negedge clk);
      check("post_rst_quiet", op_if.op_valid, 0);
    end
    s = $urandom_range(200, 33);
    run_tile("post_rst", s, (s + N - 1) / N, rand_dirs(s));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gact_tb_cigar.md
Name: gact_tb_cigar

Overview:
- Downstream consumer of the GACT tile aligner.
- After the aligner signals done, this block drains the packed traceback-direction BRAM through its read port, unpacks 2-bit directions in traceback order, and merges consecutive identical directions into run-length (op, len) records.
- Records stream out on a valid/ready interface to the host/CIGAR writer.
- Sits between the aligner's dir BRAM read port and the host result FIFO.

Parameters:
- NUM_DIR_BLOCK, 32, directions packed per BRAM word (word width 2*NUM_DIR_BLOCK).
- DIR_BRAM_ADDR_WIDTH, 5, dir BRAM address width.
- MAX_TILE_SIZE, 512, maximum tile length; LW = 2*$clog2(MAX_TILE_SIZE) is the step/length width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latch inputs and begin draining; ignored unless idle.
- num_tb_steps  in  LW  total directions stored; sampled on start.
- dir_total_count  in  DIR_BRAM_ADDR_WIDTH  words written; sampled on start.
- dir_rd_addr  out  DIR_BRAM_ADDR_WIDTH  BRAM read address; data returns 1 cycle later.
- dir_data_out  in  2*NUM_DIR_BLOCK  BRAM read data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last record is accepted, or on error.
- error  out  1  sticky count-mismatch flag; cleared by the next accepted start or by rst.
- op_valid  out  1  record valid.
- op_ready  in  1  downstream accept.
- op_code  out  2  1=M (diag), 2=I (ref gap / query advance), 3=D (query gap / ref advance).
- op_len  out  LW  run length, 1 or more.

Behaviour:
- Reset values: busy=0, done=0, error=0, op_valid=0, op_code=0, op_len=0, dir_rd_addr=0, FSM in IDLE.
- Reset mid-operation aborts immediately; no further records are produced.
- Word packing:
  - Each full word holds NUM_DIR_BLOCK directions, first in bits [2N-1:2N-2] and last in [1:0].
  - The final word holds r = num_tb_steps mod NUM_DIR_BLOCK directions when r≠0, packed in the low 2r bits, first at [2r-1:2r-2].
- Required words: W = ceil(num_tb_steps / NUM_DIR_BLOCK).
  - If W ≠ dir_total_count at start: set error, pulse done the next cycle, emit nothing.
- FSM states: IDLE, FETCH, WAIT, UNPACK, FLUSH, FIN.
  - IDLE: on start, go to FETCH with addr=0.
    - If num_tb_steps=0 and dir_total_count=0, go straight to FIN with no records.
  - FETCH: drive dir_rd_addr, then WAIT (1-cycle read latency). Load the shift register; set the per-word count to NUM_DIR_BLOCK, or to r for the last word.
  - UNPACK: consume one direction per cycle, MSB-first within the valid field.
    - If the code equals the current run code: increment the run length.
    - Otherwise: present the previous run as a record and start a new run with len=1.
    - The first direction of the tile starts a run without emitting.
    - Code 0 is skipped; it neither breaks nor extends a run.
    - When the word is exhausted: go to FETCH with addr+1, or to FLUSH if it was the last word.
  - FLUSH: emit the open run if len>0, then go to FIN.
  - FIN: pulse done, go to IDLE.
- Handshake:
  - op_valid stays high, and op_code/op_len stay stable, until op_ready.
  - While op_valid && !op_ready, UNPACK stalls (no direction consumed).
  - The next record may be presented the cycle after acceptance.
  - Throughput: at most one direction per cycle, plus 2 cycles per word fetch.
- op_len never overflows: the maximum run is num_tb_steps < 2^LW.
- A start pulse while busy is ignored.

Optional Feature:
- GACT_TB_CIGAR_TALLY_EN:
  - Adds outputs ref_bases[LW-1:0] and query_bases[LW-1:0], reset to 0 and cleared on start.
  - Each accepted record adds op_len to ref_bases for M/D and to query_bases for M/I.
  - Values are final when done pulses.
- Without the macro: these ports and counters do not exist.

Test Plan:
- num_tb_steps=32, count=1, word = all 01 -> one record M,32; done 1 cycle after acceptance; error=0.
- num_tb_steps=5, count=1, low 10 bits = 01 01 10 11 11 -> records M,2 then I,1 then D,2.
- num_tb_steps=40, count=2, word0 all M, word1 low 16 bits all M -> single record M,40 (run spans the word boundary).
- Same as the previous case with op_ready held low for 10 cycles -> op_valid and fields stable, no loss, identical output.
- num_tb_steps=40, count=1 -> error=1, done pulse, no op_valid; next valid start clears error.
- rst asserted mid-UNPACK -> next cycle all outputs 0, FSM idle; a following start produces a correct full sequence.
